// File: rtl/display_pkg.sv
// Shared types and hex decode for the 7-segment display blocks.
// Segment vectors are {a,b,c,d,e,f,g}, active-low.
package display_pkg;

    typedef enum logic {BLANK = 1'b0, ON = 1'b1} slot_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_scan_n_if.sv
// Datapath-facing inputs and pin-facing outputs of the digit scanner.
interface display_scan_n_if #(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   en_mask;
    logic [BRIGHT_W-1:0]   brightness;
    logic [N_DIGITS-1:0]   an;
    logic [6:0]            seg;
    logic                  dp_n;
    logic                  frame_start;

    modport master (
        output digits, dp, en_mask, brightness,
        input  an, seg, dp_n, frame_start
    );

    modport slave (
        input  digits, dp, en_mask, brightness,
        output an, seg, dp_n, frame_start
    );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = hex_to_seg(hex);
endmodule

// File: rtl/display_scan_n.sv
// Time-multiplexed N-digit common-anode scanner with anti-ghost blanking,
// PWM dimming and a per-frame snapshot of all display inputs.
module display_scan_n
    import display_pkg::*;
#(
    parameter int N_DIGITS        = 8,
    parameter int TICKS_PER_DIGIT = 1024,
    parameter int BLANK_TICKS     = 16,
    parameter int BRIGHT_W        = 4
) (
    input logic             clk,
    input logic             reset,
    display_scan_n_if.slave bus
);
    localparam int ON_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;
    localparam int CW       = $clog2(TICKS_PER_DIGIT);
    localparam int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    if (N_DIGITS < 1 || N_DIGITS > 16) begin : g_bad_n
        $error("N_DIGITS must be within 1..16");
    end
    if (BLANK_TICKS < 1 || BLANK_TICKS > TICKS_PER_DIGIT - 1) begin : g_bad_blank
        $error("BLANK_TICKS must be within 1..TICKS_PER_DIGIT-1");
    end

    slot_state_t            state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [IW-1:0]          idx, idx_nx;
    logic [BRIGHT_W-1:0]    pwm, pwm_nx;

    logic [N_DIGITS-1:0][3:0] sh_dig;
    logic [N_DIGITS-1:0]    sh_dp, sh_en;
    logic [BRIGHT_W-1:0]    sh_br;

    logic                   snap, lit;
    logic [6:0]             dec_seg;
    logic [N_DIGITS-1:0]    an_nx;
    logic [6:0]             seg_nx;
    logic                   dpn_nx;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
            pwm   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            pwm   <= pwm_nx;
        end
    end

    // next state; pwm sits at zero through BLANK so ON always starts from 0
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        pwm_nx   = '0;
        case (state)
            BLANK: begin
                if (cnt == CW'(BLANK_TICKS - 1)) begin
                    state_nx = ON;
                    cnt_nx   = '0;
                end
            end
            ON: begin
                pwm_nx = pwm + 1'b1;
                if (cnt == CW'(ON_TICKS - 1)) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
                end
            end
            default: state_nx = BLANK;
        endcase
    end

    assign snap = (state == BLANK) && (idx == '0) && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_dig <= '0;
            sh_dp  <= '0;
            sh_en  <= '0;
            sh_br  <= '0;
        end else if (snap) begin
            sh_dig <= bus.digits;
            sh_dp  <= bus.dp;
            sh_en  <= bus.en_mask;
            sh_br  <= bus.brightness;
        end
    end

    seg7_hex_decoder u_dec (
        .hex (sh_dig[idx]),
        .seg (dec_seg)
    );

    // outputs
    always_comb begin
        lit    = (state == ON) && sh_en[idx] && (pwm <= sh_br);
        an_nx  = '1;
        seg_nx = SEG_OFF;
        dpn_nx = 1'b1;
        if (lit) begin
            an_nx[idx] = 1'b0;
            seg_nx     = dec_seg;
            dpn_nx     = ~sh_dp[idx];
        end
    end

    // pins are registered so nothing from the inputs reaches them combinationally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.an          <= '1;
            bus.seg         <= SEG_OFF;
            bus.dp_n        <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an          <= an_nx;
            bus.seg         <= seg_nx;
            bus.dp_n        <= dpn_nx;
            bus.frame_start <= snap;
        end
    end

endmodule

// File: tb/tb_display_scan_n.sv
// Randomized bench for display_scan_n against a frame-position reference model.
module tb_display_scan_n;
    localparam int N  = 4;
    localparam int T  = 8;
    localparam int B  = 2;
    localparam int W  = 2;
    localparam int FR = N * T;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    display_scan_n_if #(.N_DIGITS(N), .BRIGHT_W(W)) bus ();

    display_scan_n #(
        .N_DIGITS(N), .TICKS_PER_DIGIT(T), .BLANK_TICKS(B), .BRIGHT_W(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;
    int t = 0;

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    logic [3:0]   m_dig [N];
    logic [N-1:0] m_dp, m_en;
    logic [W-1:0] m_br;
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dpn, e_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // expected pins after this edge, from the position within the frame
    task automatic model_edge();
        int pos, di, w, k;
        e_an = '1; e_seg = 7'h7F; e_dpn = 1'b1; e_fs = 1'b0;
        if (!reset) begin
            t = 0;
            return;
        end
        pos = t % FR;
        di  = pos / T;
        w   = pos % T;
        if (pos == 0) begin
            e_fs = 1'b1;
            for (int i = 0; i < N; i++) m_dig[i] = bus.digits[4*i +: 4];
            m_dp = bus.dp;
            m_en = bus.en_mask;
            m_br = bus.brightness;
        end
        if (w >= B) begin
            k = (w - B) % (1 << W);
            if (m_en[di] && k <= int'(m_br)) begin
                e_an[di] = 1'b0;
                e_seg    = seg_tab[m_dig[di]];
                e_dpn    = ~m_dp[di];
            end
        end
        t++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("an", bus.an, e_an);
        chk("seg", bus.seg, e_seg);
        chk("dp_n", bus.dp_n, e_dpn);
        chk("frame_start", bus.frame_start, e_fs);
        chk("one_anode", ($countones(~bus.an) <= 1), 1);
        if (bus.an == '1) chk("dark_seg", bus.seg, 7'h7F);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int p);
        int guard;
        guard = 0;
        while (t % FR != p && guard < 2 * FR) begin
            step();
            guard++;
        end
        chk("reach_pos", t % FR, p);
    endtask

    initial begin
        bus.digits = '0; bus.dp = '0; bus.en_mask = '0; bus.brightness = '0;
        run(5);
        bus.digits = 16'h3210; bus.en_mask = 4'hF; bus.brightness = 2'd3; bus.dp = 4'b0100;
        reset = 1'b1;
        run(2 * FR);
        run_until(12);
        bus.digits = 16'hFFFF;
        run(2 * FR);
        bus.digits = 16'h3210;
        bus.en_mask = 4'b0101;
        run(2 * FR);
        bus.en_mask = 4'hF;
        bus.brightness = 2'd0;
        run(2 * FR);
        bus.brightness = 2'd1;
        run(2 * FR);
        for (int i = 0; i < 40 * FR; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                bus.digits     = 16'($urandom);
                bus.dp         = 4'($urandom);
                bus.en_mask    = 4'($urandom);
                bus.brightness = 2'($urandom);
            end
            step();
        end
        bus.en_mask = 4'hF; bus.brightness = 2'd3; bus.digits = 16'hA5C7;
        run(FR);
        run_until(20);
        chk("pre_reset_lit", bus.an, 4'b1011);
        #2 reset = 1'b0;
        #1;
        chk("async_an", bus.an, 4'hF);
        chk("async_seg", bus.seg, 7'h7F);
        chk("async_dp_n", bus.dp_n, 1'b1);
        chk("async_fs", bus.frame_start, 1'b0);
        run(3);
        reset = 1'b1;
        run(2 * FR);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
